uart_autobaud: RTL and testbench
================================

Name: uart_autobaud

Overview:
- Measures the bit period of an incoming 0x55 sync character on the UART RX line.
- Produces the matching 16-bit prescale for the baud generator, using Baud = clk/((PR+1)*16).
- Sits between the RX pin and the UART prescale input, as the timing-recovery counterpart to baud generation.
- Software or a controller arms it; on success the result is loaded into the UART prescale register.

Parameters:
- CW, 20, width of the per-interval cycle counter; also sets the timeout ceiling.
- TIMEOUT, 20'hFFFFF, cycles without a falling edge after which measurement aborts.
- DEF_PRESCALE, 16'd162, reset value of the prescale output.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en  input  1  block enable; low forces IDLE synchronously
- start  input  1  one-cycle arm request
- rx  input  1  asynchronous UART RX line
- prescale  output  16  last successfully measured prescale
- busy  output  1  high in ARM, MEASURE, CALC
- done  output  1  one-cycle pulse; prescale was updated
- error  output  1  one-cycle pulse; measurement failed
- err_code  output  2  01 timeout, 10 interval mismatch, 11 out of range; holds until the next start

Behaviour:
- Reset (one clk with rst=1) sets all of the following:
  - prescale=DEF_PRESCALE, busy=0, done=0, error=0, err_code=00, state=IDLE.
  - Synchronizer flops =1.
- rx passes through a 2-flop synchronizer to give rx_s. fall = rx_s_prev & ~rx_s.
- States:
  - IDLE: start & en -> ARM; clear err_code and counters.
  - ARM: wait for rx_s==1, so a line already low is not taken as a start bit.
    - Then the first fall -> MEASURE; set edge_cnt=1, ivl=0.
  - MEASURE: ivl increments every cycle.
    - On fall: store ivl as I[edge_cnt-1], reset ivl=0, increment edge_cnt.
    - The 5th fall (edge_cnt==4 before increment) -> CALC.
    - The pattern is start,1,0,1,0,1,0,1,0,stop. Falls occur at start, b1, b3, b5, b7, giving four intervals of 2 bit-times each.
  - CALC (one cycle), computed on the stored intervals:
    - N = I0+I1+I2+I3, width CW+2.
    - mismatch if any |Ik - I0| > (I0>>2), k=1..3.
    - PRn = ((N + 64) >> 7) - 1.
    - range error if N < 128 or PRn > 65535.
    - Priority: mismatch first, then range.
    - On success: prescale <= PRn[15:0], done pulses.
    - On failure: error pulses, err_code set, prescale unchanged.
    - -> IDLE.
- Timeout: in ARM or MEASURE, if ivl reaches TIMEOUT: error pulses, err_code=01, -> IDLE.
  - In ARM, ivl counts from entry, so a stuck-low line also times out.
- Latency: done/error are registered outputs. They are asserted exactly 2 clk after the cycle in which fall is high for the 5th edge: one cycle to enter CALC, one to register.
- start while busy is ignored. done and error are never high together.
- en low at any time: state -> IDLE on the next clk, busy=0, no done/error pulse, prescale held.
- rst mid-measurement behaves like power-on reset; prescale returns to DEF_PRESCALE.
- All arithmetic is unsigned. ivl saturates at TIMEOUT and never wraps.

Test Plan:
- Nominal: rst; start; after 10 idle-high clk send 0x55 8N1 at 64 clk/bit -> N=512, done pulse 2 clk after the 5th fall, prescale=3, err_code=00, busy drops with done.
- Slow rate: 0x55 at 2608 clk/bit -> N=20864, prescale=162; then a second run at 16 clk/bit -> prescale=0, done.
- Mismatch: 0x55 with bit 3 stretched so I1=1.5*I0 (I0=128) -> error pulse, err_code=10, prescale keeps its previous value.
- Timeout: TIMEOUT=1000, start, rx held high after ARM -> error at ivl=1000, err_code=01, busy=0; repeat with rx stuck low from start -> err_code=01.
- Range: 0x55 at 4 clk/bit (N=32) -> err_code=11, no done.
- Control: start during MEASURE is ignored and the result is unaffected. en dropped mid-byte -> IDLE next clk, no pulses. rst mid-byte -> prescale=162, busy=0.

Source files
------------

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the bit period of a 0x55 sync character and derives the UART prescale
module uart_autobaud #(
   parameter int              CW           = 20,
   parameter logic [CW-1:0]   TIMEOUT      = 20'hFFFFF,
   parameter logic [15:0]     DEF_PRESCALE = 16'd162
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        start_i,
   input  logic        rx_i,
   output logic [15:0] prescale_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [1:0]  err_code_o
);
   localparam int NW = CW + 2;
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, CALC} state_t;
   state_t        state_q, state_d;
   logic          sync1_q, rx_s_q, rx_prev_q;
   logic          seen_q, seen_d;
   logic [CW-1:0] ivl_q, ivl_d, ivl_inc;
   logic [2:0]    cnt_q, cnt_d;
   logic [CW-1:0] ivs_q [4];
   logic [CW-1:0] ivs_d [4];
   logic [15:0]   prescale_q, prescale_d;
   logic          done_q, done_d, error_q, error_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          fall, timeout, mismatch, range_err;
   logic [NW-1:0] n_sum, prn;
   logic [CW-1:0] dif;
   assign fall     = rx_prev_q & ~rx_s_q;
   assign timeout  = ivl_q == TIMEOUT;
   assign ivl_inc  = timeout ? ivl_q : ivl_q + CW'(1);
   assign prescale_o = prescale_q;
   assign busy_o     = state_q != IDLE;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign err_code_o = err_code_q;
   // sum, consistency and prescale derivation over the four stored 2-bit-time intervals
   always_comb begin
      n_sum = NW'(ivs_q[0]) + NW'(ivs_q[1]) + NW'(ivs_q[2]) + NW'(ivs_q[3]);
      mismatch = 1'b0;
      dif = '0;
      for (int k = 1; k < 4; k++) begin
         dif = (ivs_q[k] > ivs_q[0]) ? ivs_q[k] - ivs_q[0] : ivs_q[0] - ivs_q[k];
         mismatch = mismatch | (dif > (ivs_q[0] >> 2));
      end
      prn = ((n_sum + NW'(64)) >> 7) - NW'(1);
      range_err = (n_sum < NW'(128)) | (prn > NW'(65535));
   end
   // next-state logic; the interval counter includes the edge cycle so a clean period of B clocks stores 2B
   always_comb begin
      state_d    = state_q;
      seen_d     = seen_q;
      ivl_d      = ivl_q;
      cnt_d      = cnt_q;
      ivs_d      = ivs_q;
      prescale_d = prescale_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = err_code_q;
      if (!en_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_d    = ARM;
                  err_code_d = 2'b00;
                  ivl_d      = '0;
                  cnt_d      = '0;
                  seen_d     = 1'b0;
               end
            end
            ARM: begin
               ivl_d = ivl_inc;
               if (timeout) begin
                  state_d    = IDLE;
                  error_d    = 1'b1;
                  err_code_d = 2'b01;
               end else begin
                  seen_d = seen_q | rx_s_q;
                  if (seen_q && fall) begin
                     state_d = MEASURE;
                     cnt_d   = 3'd1;
                     ivl_d   = '0;
                  end
               end
            end
            MEASURE: begin
               ivl_d = ivl_inc;
               if (timeout) begin
                  state_d    = IDLE;
                  error_d    = 1'b1;
                  err_code_d = 2'b01;
               end else if (fall) begin
                  ivs_d[cnt_q[1:0] - 2'd1] = ivl_inc;
                  ivl_d = '0;
                  cnt_d = cnt_q + 3'd1;
                  state_d = (cnt_q == 3'd4) ? CALC : MEASURE;
               end
            end
            CALC: begin
               state_d = IDLE;
               if (mismatch) begin
                  error_d    = 1'b1;
                  err_code_d = 2'b10;
               end else if (range_err) begin
                  error_d    = 1'b1;
                  err_code_d = 2'b11;
               end else begin
                  prescale_d = prn[15:0];
                  done_d     = 1'b1;
               end
            end
         endcase
      end
   end
   // RX synchronizer and edge-detect history, idle-high after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx_i;
         rx_s_q    <= sync1_q;
         rx_prev_q <= rx_s_q;
      end
   end
   // state and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         seen_q     <= 1'b0;
         ivl_q      <= '0;
         cnt_q      <= '0;
         ivs_q      <= '{default: '0};
         prescale_q <= DEF_PRESCALE;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         seen_q     <= seen_d;
         ivl_q      <= ivl_d;
         cnt_q      <= cnt_d;
         ivs_q      <= ivs_d;
         prescale_q <= prescale_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end
endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: randomized 0x55 frames checked against an interval-arithmetic reference model
module tb_uart_autobaud;
   logic        clk = 1'b0;
   logic        rst, en, start, rx, t_start, t_rx;
   logic [15:0] prescale, t_prescale;
   logic        busy, done, error, t_busy, t_done, t_error;
   logic [1:0]  err_code, t_err_code;
   int errs = 0, checks = 0;
   int cyc = 0;
   int n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0, both = 0;
   logic done_busy = 1'b0;
   int dur [10];
   int fall5 = 0, nd = 0, ne = 0, exp_ps = 162;
   always #5 clk = ~clk;
   uart_autobaud dut (
      .clk(clk), .rst(rst), .en_i(en), .start_i(start), .rx_i(rx),
      .prescale_o(prescale), .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code)
   );
   uart_autobaud #(.TIMEOUT(20'd1000)) dut_t (
      .clk(clk), .rst(rst), .en_i(en), .start_i(t_start), .rx_i(t_rx),
      .prescale_o(t_prescale), .busy_o(t_busy), .done_o(t_done), .error_o(t_error), .err_code_o(t_err_code)
   );
   // cycle stamp
   always @(posedge clk) cyc <= cyc + 1;
   // pulse monitor for the main instance, sampled away from the active edge
   always @(negedge clk) begin
      if (done) begin
         n_done    <= n_done + 1;
         done_cyc  <= cyc;
         done_busy <= busy;
      end
      if (error) begin
         n_err   <= n_err + 1;
         err_cyc <= cyc;
      end
      if (done && error) both <= both + 1;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic set_uniform(input int b);
      for (int i = 0; i < 10; i++) dur[i] = b;
   endtask
   task automatic arm();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      nd = n_done;
      ne = n_err;
   endtask
   // start, b0..b7 = 1,0,1,0,1,0,1,0 (0x55 LSB first), stop
   task automatic send_frame();
      for (int i = 0; i < 10; i++) begin
         rx = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : 1'(i % 2);
         if (i == 8) fall5 = cyc;
         repeat (dur[i]) @(negedge clk);
      end
      rx = 1'b1;
   endtask
   task automatic verify(input string tag);
      int iv [4];
      int n, pr, d;
      bit mm;
      logic [1:0] code;
      n = 0;
      mm = 1'b0;
      for (int k = 0; k < 4; k++) begin
         iv[k] = dur[2*k] + dur[2*k+1];
         n += iv[k];
      end
      for (int k = 1; k < 4; k++) begin
         d = (iv[k] > iv[0]) ? iv[k] - iv[0] : iv[0] - iv[k];
         if (d > iv[0] / 4) mm = 1'b1;
      end
      pr = (n + 64) / 128 - 1;
      code = mm ? 2'd2 : (n < 128 || pr > 65535) ? 2'd3 : 2'd0;
      if (code == 2'd0) begin
         check({tag, ".done_cnt"}, n_done - nd, 1);
         check({tag, ".err_cnt"}, n_err - ne, 0);
         check({tag, ".done_lat"}, done_cyc - fall5, 4);
         check({tag, ".busy_at_done"}, done_busy, 0);
         check({tag, ".prescale"}, prescale, pr);
         exp_ps = pr;
      end else begin
         check({tag, ".err_cnt"}, n_err - ne, 1);
         check({tag, ".done_cnt"}, n_done - nd, 0);
         check({tag, ".err_lat"}, err_cyc - fall5, 4);
         check({tag, ".prescale_held"}, prescale, exp_ps);
      end
      check({tag, ".err_code"}, err_code, code);
      check({tag, ".busy_end"}, busy, 0);
   endtask
   task automatic run(input string tag);
      arm();
      send_frame();
      repeat (20) @(negedge clk);
      verify(tag);
   endtask
   task automatic t_run(input string tag);
      int s, el;
      t_start = 1'b1;
      @(negedge clk);
      t_start = 1'b0;
      s = cyc - 1;
      check({tag, ".busy_armed"}, t_busy, 1);
      check({tag, ".code_cleared"}, t_err_code, 0);
      for (int k = 0; k < 1500 && !t_error; k++) @(negedge clk);
      el = cyc - s;
      check({tag, ".error_seen"}, t_error, 1);
      check({tag, ".latency_window"}, (el >= 990 && el <= 1010), 1);
      check({tag, ".err_code"}, t_err_code, 2'b01);
      check({tag, ".busy"}, t_busy, 0);
      check({tag, ".no_done"}, t_done, 0);
      @(negedge clk);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      rst = 1'b1; en = 1'b1; start = 1'b0; rx = 1'b1; t_start = 1'b0; t_rx = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.prescale", prescale, 162);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.error", error, 0);
      check("rst.err_code", err_code, 0);
      rst = 1'b0;
      @(negedge clk);
      set_uniform(64);
      run("nominal");
      set_uniform(2608);
      run("slow");
      set_uniform(16);
      run("fast");
      set_uniform(64);
      dur[3] = 128;
      run("mismatch");
      set_uniform(4);
      run("range");
      for (int r = 0; r < 6; r++) begin
         int b;
         b = $urandom_range(6, 200);
         for (int i = 0; i < 10; i++) dur[i] = b + int'($urandom_range(0, b / 3)) - b / 6;
         if ($urandom_range(0, 3) == 0) dur[$urandom_range(0, 7)] += b;
         run($sformatf("rnd%0d", r));
      end
      set_uniform(64);
      fork
         run("start_in_measure");
         begin
            repeat (300) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      arm();
      fork
         send_frame();
         begin
            repeat (200) @(negedge clk);
            check("en.busy_before", busy, 1);
            en = 1'b0;
            @(negedge clk);
            check("en.busy_after", busy, 0);
            en = 1'b1;
         end
      join
      repeat (20) @(negedge clk);
      check("en.no_done", n_done - nd, 0);
      check("en.no_error", n_err - ne, 0);
      check("en.prescale_held", prescale, exp_ps);
      arm();
      fork
         send_frame();
         begin
            repeat (200) @(negedge clk);
            check("rst_mid.busy_before", busy, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_mid.prescale", prescale, 162);
            check("rst_mid.busy", busy, 0);
         end
      join
      repeat (20) @(negedge clk);
      check("rst_mid.no_done", n_done - nd, 0);
      check("rst_mid.no_error", n_err - ne, 0);
      exp_ps = 162;
      t_rx = 1'b1;
      repeat (5) @(negedge clk);
      t_run("timeout_high");
      t_rx = 1'b0;
      repeat (5) @(negedge clk);
      t_run("timeout_low");
      t_rx = 1'b1;
      check("done_error_exclusive", both, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
